demux1_4: RTL
=============

# demux1_4

Registered 1-to-4 stream demultiplexer, the distributing counterpart of the 4:1 select mux used across the datapath. It accepts one word per cycle on a single valid/ready input and routes it to one of four output ports, chosen by a 2-bit select (sel1 = MSB, sel0 = LSB). Each output has a one-entry holding register, so the datapath and its consumers are decoupled. It sits between the forwarding/writeback stage and its four consumers.

## Interface
- WIDTH, 64: data word width in bits.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to route.
- in_sel0  input  1  destination select, LSB.
- in_sel1  input  1  destination select, MSB.
- in_valid  input  1  in_data/in_sel* valid this cycle.
- in_ready  output  1  word accepted when in_valid && in_ready.
- out_data0..out_data3  output  WIDTH each  holding-register contents per port.
- out_valid  output  4  bit k = port k holds a word.
- out_ready  input  4  bit k = consumer k takes the word this cycle.
- acc_count  output  16  accepted-word counter (only with DEMUX1_4_COUNT_EN).

## Operation
- Port index k = {in_sel1, in_sel0}: 00->0, 01->1, 10->2, 11->3, matching the i00/i01/i10/i11 order of the 4:1 mux.
- Per-port state machine, two states:
  - EMPTY: out_valid[k]=0. On accept with index k -> FULL; load out_data{k}.
  - FULL: out_valid[k]=1, out_data{k} held stable.
    - out_ready[k]=1 with no accept to k -> EMPTY.
    - out_ready[k]=1 with an accept to k -> stays FULL, reloads with new word (back-to-back).
    - out_ready[k]=0 -> stays FULL, no change.
- in_ready = (port k EMPTY) || out_ready[k], for k from the current in_sel*. Combinational from in_sel*, out_ready and state; no combinational path from in_data.
- Only the selected port can change on input acceptance; other ports drain independently in the same cycle.
- in_valid=0: in_sel* ignored. in_ready is still driven from in_sel*; its value is don't-care.
- Upstream must hold in_data and in_sel* stable while in_valid && !in_ready. Changing in_sel* before acceptance is a protocol violation; behaviour is then undefined.
- out_data{k} updates only on acceptance into port k; otherwise it retains its last value, even when EMPTY.

## Timing
- Reset (async assert, sync release on clk): all ports EMPTY, out_valid=4'b0000, out_data0..3=0, acc_count=0. in_ready=1 when out of reset.
- Latency: word accepted at edge N appears on out_data{k} with out_valid[k]=1 in the cycle after edge N.
- Throughput: 1 word/cycle per port with out_ready held high. Words to different ports are also accepted 1/cycle.
- Reset asserted mid-transfer: held words are discarded, no partial state. The first accept after release is counted from 0.
- Simultaneous drain of port j and accept into port k (j≠k): both take effect at the same edge.

## Configuration
- DEMUX1_4_COUNT_EN defined:
  - acc_count port exists.
  - Increments by 1 on every in_valid && in_ready edge.
  - Wraps 16'hFFFF -> 0; reset to 0.
- DEMUX1_4_COUNT_EN undefined:
  - acc_count port and counter logic are absent.
  - Routing behaviour is identical.

## Test plan
- Reset: drive reset=0 mid-run with ports full -> out_valid=0000, out_data0..3=0 immediately (asynchronous). in_ready=1 after release.
- Routing: out_ready=1111; send 0xA0,0xA1,0xA2,0xA3 with sel {1,1},{1,0},{0,1},{0,0} on consecutive cycles -> out_data3=0xA0, out_data2=0xA1, out_data1=0xA2, out_data0=0xA3. Each arrives one cycle after acceptance, with a single out_valid bit per cycle.
- Backpressure: out_ready[2]=0; send 0x11 then 0x22 to port 2 -> 0x11 held, in_ready=0 on the second word. Raise out_ready[2] -> 0x11 consumed and 0x22 accepted at the same edge; 0x22 valid the next cycle.
- Independence: port 1 full and stalled; send 0x55 to port 0 -> accepted, out_valid=0011, port 1 data unchanged.
- Back-to-back: out_ready[3]=1, send 8 consecutive words to port 3 -> in_ready stays 1, all 8 appear in order with no bubbles.
- Counter (DEMUX1_4_COUNT_EN): preload via 65535 accepts -> acc_count=0xFFFF. One more accept -> 0x0000. Stalled cycles do not increment.

Source files
------------

// File: rtl/demux1_4.sv
// Registered 1-to-4 valid/ready stream demultiplexer with a one-entry holding register per output port.
// Optional accepted-word counter on acc_count when DEMUX1_4_COUNT_EN is defined.
module demux1_4 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel0,
  input  logic             in_sel1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX1_4_COUNT_EN
  ,
  output logic [15:0]      acc_count
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } port_state_t;

  port_state_t      r_state [4];
  logic [WIDTH-1:0] r_data  [4];

  logic [1:0] w_idx;
  logic       w_accept;

  assign w_idx    = {in_sel1, in_sel0};
  // A full port can still take a word in the same cycle its consumer drains it.
  assign in_ready = (r_state[w_idx] == EMPTY) || out_ready[w_idx];
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        r_state[k] <= EMPTY;
        r_data[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_accept && (w_idx == 2'(k))) begin
          r_state[k] <= FULL;
          r_data[k]  <= in_data;
        end else if ((r_state[k] == FULL) && out_ready[k]) begin
          r_state[k] <= EMPTY;
        end
      end
    end
  end

  always_comb begin
    out_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = (r_state[k] == FULL);
    end
  end

  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];

`ifdef DEMUX1_4_COUNT_EN
  logic [15:0] r_acc_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc_count <= '0;
    end else if (w_accept) begin
      r_acc_count <= r_acc_count + 16'd1;
    end
  end

  assign acc_count = r_acc_count;
`endif

endmodule
